store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_SIZE, default 4, number of store entries (2..8).
REQ-002 SHALL have parameter ROB_IDX_W, default 4, ROB index width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_alloc  input  1  execute delivers a resolved store.
REQ-006 SHALL have ports in_alloc_rob_idx (ROB_IDX_W), in_alloc_addr (32), in_alloc_data (32), in_alloc_size (2: 00 byte, 01 half, 10 word), all inputs, store payload.
REQ-007 SHALL have port in_commit  input  1  ROB retires a store; in_commit_rob_idx  input  ROB_IDX_W  its tag.
REQ-008 SHALL have port in_nuke  input  1  pipeline flush from ROB.
REQ-009 SHALL have outputs out_cache_req (1), out_cache_addr (32), out_cache_data (32), out_cache_size (2): drain request to D-cache; in_cache_ready  input  1  cache accepts.
REQ-010 SHALL have port in_load_addr  input  32  address of load in execute.
REQ-011 SHALL have outputs out_fwd_hit (1), out_fwd_data (32), out_fwd_conflict (1): load lookup result.
REQ-012 SHALL have outputs out_full (1), out_empty (1).

Function
REQ-013 SHALL be a circular FIFO; head = oldest, tail = next free; pointers wrap SB_SIZE-1 -> 0.
REQ-014 Each entry SHALL hold valid, committed, rob_idx, addr, data, size.
REQ-015 in_alloc with !out_full SHALL write entry at tail, valid=1, committed=0, advance tail next cycle; in_alloc while full SHALL be dropped (upstream must stall on out_full).
REQ-016 in_commit SHALL set committed=1 on the valid uncommitted entry whose rob_idx matches; no match SHALL be ignored.
REQ-017 out_cache_req SHALL be 1 combinationally when head entry is valid and committed, with head payload on out_cache_*.
REQ-018 out_cache_req && in_cache_ready SHALL invalidate head and advance head next cycle; payload SHALL stay stable while req && !ready.
REQ-019 Alloc and drain in the same cycle SHALL both take effect; count unchanged.
REQ-020 in_nuke SHALL invalidate all uncommitted entries and rewind tail to head + committed count; committed entries SHALL survive and keep draining.
REQ-021 Same-cycle in_nuke and in_alloc: alloc SHALL be dropped; in_nuke and in_commit: commit SHALL apply first, entry survives; in_nuke and drain handshake: drain SHALL complete.
REQ-022 out_full SHALL be count==SB_SIZE; out_empty SHALL be count==0; both from registered state.
REQ-023 Lookup SHALL compare in_load_addr[31:2] against every valid entry, committed or not, in the same cycle, youngest wins.
REQ-024 Youngest match is a word store -> out_fwd_hit=1, out_fwd_data=its data; youngest match is byte/half -> out_fwd_conflict=1, out_fwd_hit=0 (load retries).

Reset
REQ-025 Reset SHALL clear all valid/committed bits, head=tail=count=0.
REQ-026 Outputs after reset: out_cache_req=0, out_cache_*=0, out_fwd_hit=0, out_fwd_data=0, out_fwd_conflict=0, out_full=0, out_empty=1.
REQ-027 Reset mid-drain SHALL discard all entries, including committed ones.

Configuration
REQ-028 With SB_LOAD_FORWARD_EN defined, REQ-024 forwarding SHALL apply.
REQ-029 Without SB_LOAD_FORWARD_EN, out_fwd_hit and out_fwd_data SHALL be tied 0 and any word-address match SHALL assert out_fwd_conflict.

Structure
REQ-030 SB_SIZE default, size encodings (SIZE_BYTE/HALF/WORD) and ROB_IDX_W SHALL live in the shared core package.
REQ-031 Lookup SHALL be a sub-module sb_fwd_match (entry arrays + in_load_addr in, hit/data/conflict out); everything else stays in store_buffer.

Verification
REQ-032 Alloc word @0x100 data 0xDEADBEEF tag 3, commit tag 3, ready=1 -> cache req addr 0x100 data 0xDEADBEEF the cycle after commit; out_empty=1 next cycle.
REQ-033 Fill 4 entries, 5th alloc -> dropped, out_full=1; one drain -> out_full=0 next cycle.
REQ-034 Tags 1,2,3 allocated, 1 committed, nuke -> only entry 1 remains, drains; tail = head+1.
REQ-035 Stores @0x200 data 0x11 then 0x22 (both word), load 0x200 -> fwd_hit=1, data 0x22; byte store @0x201 then load 0x200 -> fwd_conflict=1.
REQ-036 Head committed, ready=0 for 3 cycles -> req held with stable payload; alloc+drain same cycle keeps count constant across pointer wrap.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared core package for the store buffer: default sizing and store size encodings.
package store_buffer_pkg;

  localparam int SB_SIZE_DEFAULT   = 4;
  localparam int ROB_IDX_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } sb_size_e;

endpackage

// File: rtl/store_buffer_fwd_match.sv
// sb_fwd_match: load-address lookup across all valid store entries, youngest match wins.
// Forwarding of word stores is enabled by SB_LOAD_FORWARD_EN; otherwise every match is a conflict.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int SB_SIZE = SB_SIZE_DEFAULT,
  parameter int PTR_W   = $clog2(SB_SIZE)
) (
  input  logic [SB_SIZE-1:0] entry_valid,
  input  logic [31:0]        entry_addr [SB_SIZE],
  input  logic [31:0]        entry_data [SB_SIZE],
  input  logic [1:0]         entry_size [SB_SIZE],
  input  logic [PTR_W-1:0]   head,
  input  logic [31:0]        load_addr,
  output logic               fwd_hit,
  output logic [31:0]        fwd_data,
  output logic               fwd_conflict
);

  logic        match;
  logic [31:0] mdata;
  logic [1:0]  msize;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    match = 1'b0;
    mdata = '0;
    msize = '0;
    for (int k = 0; k < SB_SIZE; k++) begin
      int j;
      logic [PTR_W-1:0] idx;
      j = int'(head) + k;
      if (j >= SB_SIZE) j = j - SB_SIZE;
      idx = PTR_W'(j);
      if (entry_valid[idx] && (entry_addr[idx][31:2] == load_addr[31:2])) begin
        match = 1'b1;
        mdata = entry_data[idx];
        msize = entry_size[idx];
      end
    end
  end

  logic unused_load_lsb;
  assign unused_load_lsb = ^load_addr[1:0];

`ifdef SB_LOAD_FORWARD_EN
  assign fwd_hit      = match && (msize == SIZE_WORD);
  assign fwd_data     = fwd_hit ? mdata : '0;
  assign fwd_conflict = match && (msize != SIZE_WORD);
`else
  logic unused_match_payload;
  assign unused_match_payload = ^{mdata, msize};
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
  assign fwd_conflict = match;
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of resolved stores, committed by ROB tag and drained in order to the D-cache.
// Load forwarding in the lookup sub-module is controlled by SB_LOAD_FORWARD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_SIZE   = SB_SIZE_DEFAULT,
  parameter int ROB_IDX_W = ROB_IDX_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_alloc,
  input  logic [ROB_IDX_W-1:0] in_alloc_rob_idx,
  input  logic [31:0]          in_alloc_addr,
  input  logic [31:0]          in_alloc_data,
  input  logic [1:0]           in_alloc_size,
  input  logic                 in_commit,
  input  logic [ROB_IDX_W-1:0] in_commit_rob_idx,
  input  logic                 in_nuke,
  output logic                 out_cache_req,
  output logic [31:0]          out_cache_addr,
  output logic [31:0]          out_cache_data,
  output logic [1:0]           out_cache_size,
  input  logic                 in_cache_ready,
  input  logic [31:0]          in_load_addr,
  output logic                 out_fwd_hit,
  output logic [31:0]          out_fwd_data,
  output logic                 out_fwd_conflict,
  output logic                 out_full,
  output logic                 out_empty
);

  localparam int PTR_W = $clog2(SB_SIZE);
  localparam int CNT_W = $clog2(SB_SIZE + 1);

  logic [SB_SIZE-1:0]   valid_q, committed_q, valid_n, committed_n, commit_hit;
  logic [ROB_IDX_W-1:0] rob_idx_q [SB_SIZE];
  logic [31:0]          addr_q    [SB_SIZE];
  logic [31:0]          data_q    [SB_SIZE];
  logic [1:0]           size_q    [SB_SIZE];
  logic [PTR_W-1:0]     head_q, tail_q, head_n, tail_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic                 drain, alloc_ok;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= SB_SIZE) s = s - SB_SIZE;
    return PTR_W'(s);
  endfunction

  assign out_cache_req  = valid_q[head_q] && committed_q[head_q];
  assign out_cache_addr = out_cache_req ? addr_q[head_q] : '0;
  assign out_cache_data = out_cache_req ? data_q[head_q] : '0;
  assign out_cache_size = out_cache_req ? size_q[head_q] : '0;
  assign out_full       = (count_q == CNT_W'(SB_SIZE));
  assign out_empty      = (count_q == '0);
  assign drain          = out_cache_req && in_cache_ready;
  assign alloc_ok       = in_alloc && !out_full && !in_nuke;

  always_comb begin
    commit_hit = '0;
    for (int i = 0; i < SB_SIZE; i++)
      commit_hit[i] = in_commit && valid_q[i] && !committed_q[i] &&
                      (rob_idx_q[i] == in_commit_rob_idx);
  end

  // Commits land before a nuke looks at the committed set, so a same-cycle commit survives.
  always_comb begin
    logic [SB_SIZE-1:0] cm;
    int ccnt;
    cm          = committed_q | commit_hit;
    ccnt        = 0;
    valid_n     = valid_q;
    committed_n = cm;
    head_n      = head_q;
    tail_n      = tail_q;
    count_n     = count_q;
    if (drain) begin
      valid_n[head_q]     = 1'b0;
      committed_n[head_q] = 1'b0;
      head_n              = ptr_add(head_q, 1);
    end
    if (in_nuke) begin
      for (int i = 0; i < SB_SIZE; i++)
        if (valid_q[i] && cm[i]) ccnt = ccnt + 1;
      valid_n     = valid_n & cm;
      committed_n = committed_n & valid_n;
      tail_n      = ptr_add(head_q, ccnt);
      count_n     = CNT_W'(ccnt - int'(drain));
    end else begin
      if (alloc_ok) begin
        valid_n[tail_q]     = 1'b1;
        committed_n[tail_q] = 1'b0;
        tail_n              = ptr_add(tail_q, 1);
      end
      count_n = CNT_W'(int'(count_q) + int'(alloc_ok) - int'(drain));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_n;
      committed_q <= committed_n;
      head_q      <= head_n;
      tail_q      <= tail_n;
      count_q     <= count_n;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (!reset && alloc_ok) begin
      rob_idx_q[tail_q] <= in_alloc_rob_idx;
      addr_q[tail_q]    <= in_alloc_addr;
      data_q[tail_q]    <= in_alloc_data;
      size_q[tail_q]    <= in_alloc_size;
    end
  end

  sb_fwd_match #(
    .SB_SIZE (SB_SIZE),
    .PTR_W   (PTR_W)
  ) u_fwd_match (
    .entry_valid  (valid_q),
    .entry_addr   (addr_q),
    .entry_data   (data_q),
    .entry_size   (size_q),
    .head         (head_q),
    .load_addr    (in_load_addr),
    .fwd_hit      (out_fwd_hit),
    .fwd_data     (out_fwd_data),
    .fwd_conflict (out_fwd_conflict)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain payloads are queued at commit and checked at each cache handshake.
// Lookup expectations follow SB_LOAD_FORWARD_EN the same way the design does.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_alloc;
  logic [3:0]  in_alloc_rob_idx;
  logic [31:0] in_alloc_addr;
  logic [31:0] in_alloc_data;
  logic [1:0]  in_alloc_size;
  logic        in_commit;
  logic [3:0]  in_commit_rob_idx;
  logic        in_nuke;
  logic        out_cache_req;
  logic [31:0] out_cache_addr;
  logic [31:0] out_cache_data;
  logic [1:0]  out_cache_size;
  logic        in_cache_ready;
  logic [31:0] in_load_addr;
  logic        out_fwd_hit;
  logic [31:0] out_fwd_data;
  logic        out_fwd_conflict;
  logic        out_full;
  logic        out_empty;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .in_alloc          (in_alloc),
    .in_alloc_rob_idx  (in_alloc_rob_idx),
    .in_alloc_addr     (in_alloc_addr),
    .in_alloc_data     (in_alloc_data),
    .in_alloc_size     (in_alloc_size),
    .in_commit         (in_commit),
    .in_commit_rob_idx (in_commit_rob_idx),
    .in_nuke           (in_nuke),
    .out_cache_req     (out_cache_req),
    .out_cache_addr    (out_cache_addr),
    .out_cache_data    (out_cache_data),
    .out_cache_size    (out_cache_size),
    .in_cache_ready    (in_cache_ready),
    .in_load_addr      (in_load_addr),
    .out_fwd_hit       (out_fwd_hit),
    .out_fwd_data      (out_fwd_data),
    .out_fwd_conflict  (out_fwd_conflict),
    .out_full          (out_full),
    .out_empty         (out_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_alloc  = 1'b0;
    in_commit = 1'b0;
    in_nuke   = 1'b0;
  endtask

  task automatic drive_alloc(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s);
    in_alloc         = 1'b1;
    in_alloc_rob_idx = t;
    in_alloc_addr    = a;
    in_alloc_data    = d;
    in_alloc_size    = s;
  endtask

  task automatic drive_commit(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input bit expect_drain);
    in_commit         = 1'b1;
    in_commit_rob_idx = t;
    if (expect_drain) sb_q.push_back('{addr: a, data: d, size: s});
  endtask

  // kind: 0 no match, 1 youngest match is a word store, 2 youngest match is byte/half
  task automatic check_lookup(input string tag, input logic [31:0] la, input int kind,
                              input logic [31:0] d);
    logic        e_hit, e_conf;
    logic [31:0] e_data;
`ifdef SB_LOAD_FORWARD_EN
    e_hit  = (kind == 1);
    e_data = (kind == 1) ? d : 32'h0;
    e_conf = (kind == 2);
`else
    e_hit  = 1'b0;
    e_data = 32'h0;
    e_conf = (kind != 0);
`endif
    in_load_addr = la;
    #1;
    chk({tag, "_hit"}, {31'b0, out_fwd_hit}, {31'b0, e_hit});
    chk({tag, "_data"}, out_fwd_data, e_data);
    chk({tag, "_conflict"}, {31'b0, out_fwd_conflict}, {31'b0, e_conf});
  endtask

  task automatic wait_empty(input string tag);
    for (int n = 0; n < 20 && !out_empty; n++) tick();
    chk(tag, {31'b0, out_empty}, 32'h1);
  endtask

  always @(negedge clk) begin
    if (!reset && out_cache_req && in_cache_ready) begin
      if (sb_q.size() == 0) begin
        chk("drain_unexpected", out_cache_addr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("drain_addr", out_cache_addr, e.addr);
        chk("drain_data", out_cache_data, e.data);
        chk("drain_size", {30'b0, out_cache_size}, {30'b0, e.size});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_alloc = 1'b0; in_alloc_rob_idx = '0; in_alloc_addr = '0; in_alloc_data = '0;
    in_alloc_size = '0; in_commit = 1'b0; in_commit_rob_idx = '0; in_nuke = 1'b0;
    in_cache_ready = 1'b0; in_load_addr = 32'h0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_req", {31'b0, out_cache_req}, 32'h0);
    chk("rst_addr", out_cache_addr, 32'h0);
    chk("rst_data", out_cache_data, 32'h0);
    chk("rst_size", {30'b0, out_cache_size}, 32'h0);
    chk("rst_full", {31'b0, out_full}, 32'h0);
    chk("rst_empty", {31'b0, out_empty}, 32'h1);
    check_lookup("rst_lookup", 32'h0, 0, 32'h0);

    // Single store: alloc, commit, drain the cycle after commit
    in_cache_ready = 1'b1;
    drive_alloc(4'd3, 32'h100, 32'hDEADBEEF, SZ_W);
    tick();
    chk("s1_not_empty", {31'b0, out_empty}, 32'h0);
    chk("s1_req_pre_commit", {31'b0, out_cache_req}, 32'h0);
    drive_commit(4'd3, 32'h100, 32'hDEADBEEF, SZ_W, 1'b1);
    tick();
    chk("s1_req", {31'b0, out_cache_req}, 32'h1);
    chk("s1_addr", out_cache_addr, 32'h100);
    chk("s1_data", out_cache_data, 32'hDEADBEEF);
    tick();
    chk("s1_empty_after", {31'b0, out_empty}, 32'h1);

    // Fill, overflow drop, single drain clears full
    in_cache_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_alloc(4'(4 + i), 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), SZ_W);
      tick();
    end
    chk("fill_full", {31'b0, out_full}, 32'h1);
    drive_alloc(4'd8, 32'h400, 32'h4444, SZ_W);
    tick();
    chk("fill_still_full", {31'b0, out_full}, 32'h1);
    check_lookup("fill_dropped", 32'h400, 0, 32'h0);
    drive_commit(4'd4, 32'h300, 32'h3000, SZ_W, 1'b1);
    tick();
    chk("fill_req_head", out_cache_addr, 32'h300);
    in_cache_ready = 1'b1;
    tick();
    chk("fill_not_full", {31'b0, out_full}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      drive_commit(4'(4 + i), 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), SZ_W, 1'b1);
      tick();
    end
    wait_empty("fill_drained");

    // Nuke keeps only the committed entry; next alloc lands right behind it
    in_cache_ready = 1'b0;
    drive_alloc(4'd1, 32'h500, 32'h51, SZ_W); tick();
    drive_alloc(4'd2, 32'h504, 32'h52, SZ_W); tick();
    drive_alloc(4'd3, 32'h508, 32'h53, SZ_W); tick();
    drive_commit(4'd1, 32'h500, 32'h51, SZ_W, 1'b1); tick();
    in_nuke = 1'b1; tick();
    chk("nuke_not_empty", {31'b0, out_empty}, 32'h0);
    chk("nuke_req", {31'b0, out_cache_req}, 32'h1);
    chk("nuke_head_addr", out_cache_addr, 32'h500);
    check_lookup("nuke_gone", 32'h504, 0, 32'h0);
    drive_alloc(4'd9, 32'h600, 32'h9, SZ_W); tick();
    check_lookup("nuke_realloc", 32'h600, 1, 32'h9);
    drive_commit(4'd9, 32'h600, 32'h9, SZ_W, 1'b1);
    in_cache_ready = 1'b1;
    tick();
    wait_empty("nuke_drained");

    // Same-cycle nuke with commit (survives) and alloc (dropped), then nuke with drain
    in_cache_ready = 1'b0;
    drive_alloc(4'd10, 32'h700, 32'h70, SZ_W); tick();
    drive_commit(4'd10, 32'h700, 32'h70, SZ_W, 1'b1);
    drive_alloc(4'd11, 32'h800, 32'h80, SZ_W);
    in_nuke = 1'b1;
    tick();
    chk("nc_req", {31'b0, out_cache_req}, 32'h1);
    chk("nc_addr", out_cache_addr, 32'h700);
    check_lookup("nc_alloc_dropped", 32'h800, 0, 32'h0);
    in_nuke = 1'b1;
    in_cache_ready = 1'b1;
    tick();
    chk("nd_empty", {31'b0, out_empty}, 32'h1);

    // Lookup: youngest word wins, then a younger byte store forces a conflict
    in_cache_ready = 1'b0;
    drive_alloc(4'd1, 32'h200, 32'h11, SZ_W); tick();
    drive_alloc(4'd2, 32'h200, 32'h22, SZ_W); tick();
    check_lookup("fwd_word", 32'h200, 1, 32'h22);
    drive_alloc(4'd3, 32'h201, 32'h33, SZ_B); tick();
    check_lookup("fwd_byte", 32'h200, 2, 32'h0);
    check_lookup("fwd_byte_lane", 32'h203, 2, 32'h0);
    check_lookup("fwd_other_word", 32'h204, 0, 32'h0);
    in_nuke = 1'b1; tick();
    chk("fwd_nuked", {31'b0, out_empty}, 32'h1);

    // Backpressure holds payload stable
    drive_alloc(4'd1, 32'h900, 32'hA5A5A5A5, SZ_W); tick();
    drive_commit(4'd1, 32'h900, 32'hA5A5A5A5, SZ_W, 1'b1); tick();
    for (int c = 0; c < 3; c++) begin
      chk("hold_req", {31'b0, out_cache_req}, 32'h1);
      chk("hold_addr", out_cache_addr, 32'h900);
      chk("hold_data", out_cache_data, 32'hA5A5A5A5);
      tick();
    end
    in_cache_ready = 1'b1;
    tick();
    chk("hold_drained", {31'b0, out_empty}, 32'h1);

    // Streaming alloc+drain across pointer wrap keeps occupancy at two
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive_alloc(4'(k), 32'hA00 + 32'(4 * k), 32'hB000 + 32'(k), SZ_W);
      if (k > 0) drive_commit(4'(k - 1), 32'hA00 + 32'(4 * (k - 1)), 32'hB000 + 32'(k - 1),
                              SZ_W, 1'b1);
      tick();
      if (k >= 1 && k < 8) begin
        chk("wrap_not_empty", {31'b0, out_empty}, 32'h0);
        chk("wrap_not_full", {31'b0, out_full}, 32'h0);
      end
    end
    wait_empty("wrap_drained");

    // Reset while a committed store waits discards it
    in_cache_ready = 1'b0;
    drive_alloc(4'd5, 32'hC00, 32'hC0, SZ_W); tick();
    drive_commit(4'd5, 32'hC00, 32'hC0, SZ_W, 1'b0); tick();
    chk("mid_req", {31'b0, out_cache_req}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_req", {31'b0, out_cache_req}, 32'h0);
    chk("mid_rst_empty", {31'b0, out_empty}, 32'h1);
    chk("mid_rst_addr", out_cache_addr, 32'h0);
    in_cache_ready = 1'b1;
    repeat (2) tick();
    chk("sb_queue_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
